// File: rtl/router_pkg.sv
// Shared router definitions: output-port encoding, route-controller states,
// the XY-routing rule and the port-to-one-hot request helper.
package router_pkg;

    localparam logic [2:0] PORT_LOCAL = 3'd0;
    localparam logic [2:0] PORT_NORTH = 3'd1;
    localparam logic [2:0] PORT_EAST  = 3'd2;
    localparam logic [2:0] PORT_SOUTH = 3'd3;
    localparam logic [2:0] PORT_WEST  = 3'd4;

    // Coordinates are zero-extended to this width before comparison
    localparam int COORD_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ROUTE = 3'd1,
        ST_REQ   = 3'd2,
        ST_XFER  = 3'd3,
        ST_DONE  = 3'd4
    } route_state_e;

    // X is resolved before Y; all comparisons are unsigned
    function automatic logic [2:0] xy_route(input logic [COORD_W-1:0] src_x,
                                            input logic [COORD_W-1:0] dst_x,
                                            input logic [COORD_W-1:0] src_y,
                                            input logic [COORD_W-1:0] dst_y);
        logic [2:0] port;
        if (dst_x > src_x) begin
            port = PORT_EAST;
        end else if (dst_x < src_x) begin
            port = PORT_WEST;
        end else if (dst_y > src_y) begin
            port = PORT_SOUTH;
        end else if (dst_y < src_y) begin
            port = PORT_NORTH;
        end else begin
            port = PORT_LOCAL;
        end
        return port;
    endfunction

    function automatic logic [4:0] port_onehot(input logic [2:0] port);
        logic [4:0] vec;
        case (port)
            PORT_LOCAL: vec = 5'b00001;
            PORT_NORTH: vec = 5'b00010;
            PORT_EAST:  vec = 5'b00100;
            PORT_SOUTH: vec = 5'b01000;
            PORT_WEST:  vec = 5'b10000;
            default:    vec = 5'b00000;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/xy_route_calc.sv
// Combinational XY route: splits source/destination addresses into column (X)
// and row (Y) coordinates and returns the encoded output port.
module xy_route_calc
    import router_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int COL_BITS = 2
) (
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    output logic [2:0]        port
);

    logic [COORD_W-1:0] src_x_s;
    logic [COORD_W-1:0] dst_x_s;
    logic [COORD_W-1:0] src_y_s;
    logic [COORD_W-1:0] dst_y_s;

    // Coordinate extraction and route decision
    always_comb begin
        src_x_s = COORD_W'(src_addr[COL_BITS-1:0]);
        dst_x_s = COORD_W'(dst_addr[COL_BITS-1:0]);
        src_y_s = COORD_W'(src_addr[ADDR_W-1:COL_BITS]);
        dst_y_s = COORD_W'(dst_addr[ADDR_W-1:COL_BITS]);
        port    = xy_route(src_x_s, dst_x_s, src_y_s, dst_y_s);
    end

endmodule

// File: rtl/input0_arbiter_wrapper.sv
// Input-port-0 route/arbitration controller: route setup, output-arbiter request,
// fixed-length connection hold. Optional REQ timeout via INPUT0_ARB_TIMEOUT_EN.
module input0_arbiter_wrapper
    import router_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int COL_BITS = 2,
    parameter int PKT_LEN  = 8,
    parameter int TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              router_start_req,
    input  logic [ADDR_W-1:0] router_scr_addr,
    input  logic [ADDR_W-1:0] router_dst_addr,
    input  logic [4:0]        out_gnt,
    output logic [4:0]        out_req,
    output logic              conn_valid,
    output logic [2:0]        conn_port,
    output logic              busy,
    output logic              route_done,
    output logic              route_err
);

    localparam int PKT_CNT_W = 8;

    route_state_e         state_r;
    route_state_e         state_nxt_s;
    logic                 start_q_r;
    logic                 start_edge_s;
    logic [ADDR_W-1:0]    src_addr_r;
    logic [ADDR_W-1:0]    dst_addr_r;
    logic [2:0]           route_port_s;
    logic [2:0]           port_nxt_s;
    logic [2:0]           conn_port_r;
    logic [PKT_CNT_W-1:0] xfer_cnt_r;
    logic                 gnt_hit_s;
    logic                 pkt_last_s;
    logic                 req_expired_s;
    logic                 timeout_s;
    logic [4:0]           out_req_r;
    logic                 conn_valid_r;
    logic                 busy_r;
    logic                 route_done_r;
    logic                 route_err_r;

    xy_route_calc #(
        .ADDR_W   (ADDR_W),
        .COL_BITS (COL_BITS)
    ) u_xy_route (
        .src_addr (src_addr_r),
        .dst_addr (dst_addr_r),
        .port     (route_port_s)
    );

    assign start_edge_s = router_start_req & ~start_q_r;
    // Only the grant bit of the chosen port matters
    assign gnt_hit_s    = |(out_gnt & port_onehot(conn_port_r));
    assign pkt_last_s   = (xfer_cnt_r == PKT_CNT_W'(PKT_LEN - 1));

`ifdef INPUT0_ARB_TIMEOUT_EN
    localparam int TO_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TO_CNT_W-1:0] req_cnt_r;

    assign req_expired_s = (req_cnt_r == TO_CNT_W'(TIMEOUT - 1));

    // Counts cycles spent waiting for a grant; cleared outside REQ
    always_ff @(posedge clk) begin
        if (rst) begin
            req_cnt_r <= {TO_CNT_W{1'b0}};
        end else if (state_r == ST_REQ) begin
            req_cnt_r <= req_cnt_r + TO_CNT_W'(1);
        end else begin
            req_cnt_r <= {TO_CNT_W{1'b0}};
        end
    end
`else
    logic [31:0] unused_timeout_s;

    assign unused_timeout_s = 32'(TIMEOUT);
    assign req_expired_s    = 1'b0;
`endif

    // Next-state decision
    always_comb begin
        state_nxt_s = state_r;
        timeout_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_edge_s) begin
                    state_nxt_s = ST_ROUTE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ROUTE: state_nxt_s = ST_REQ;
            ST_REQ: begin
                if (gnt_hit_s) begin
                    state_nxt_s = ST_XFER;
                end else if (req_expired_s) begin
                    state_nxt_s = ST_IDLE;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_XFER: begin
                if (pkt_last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_XFER;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Chosen port is captured on leaving ROUTE and held until the next route
    always_comb begin
        port_nxt_s = conn_port_r;
        if (state_r == ST_ROUTE) begin
            port_nxt_s = route_port_s;
        end else begin
            port_nxt_s = conn_port_r;
        end
    end

    // State, request capture and outputs registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            start_q_r    <= 1'b0;
            src_addr_r   <= {ADDR_W{1'b0}};
            dst_addr_r   <= {ADDR_W{1'b0}};
            conn_port_r  <= PORT_LOCAL;
            out_req_r    <= 5'b00000;
            conn_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            route_done_r <= 1'b0;
            route_err_r  <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            start_q_r <= router_start_req;
            if ((state_r == ST_IDLE) && start_edge_s) begin
                src_addr_r <= router_scr_addr;
                dst_addr_r <= router_dst_addr;
            end
            conn_port_r <= port_nxt_s;
            if ((state_nxt_s == ST_REQ) || (state_nxt_s == ST_XFER)) begin
                out_req_r <= port_onehot(port_nxt_s);
            end else begin
                out_req_r <= 5'b00000;
            end
            conn_valid_r <= (state_nxt_s == ST_XFER);
            busy_r       <= (state_nxt_s != ST_IDLE);
            route_done_r <= (state_nxt_s == ST_DONE);
            route_err_r  <= timeout_s;
        end
    end

    // Connection hold counter, zero on XFER entry
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt_r <= {PKT_CNT_W{1'b0}};
        end else if (state_r == ST_XFER) begin
            xfer_cnt_r <= xfer_cnt_r + PKT_CNT_W'(1);
        end else begin
            xfer_cnt_r <= {PKT_CNT_W{1'b0}};
        end
    end

    assign out_req    = out_req_r;
    assign conn_valid = conn_valid_r;
    assign conn_port  = conn_port_r;
    assign busy       = busy_r;
    assign route_done = route_done_r;
    assign route_err  = route_err_r;

endmodule

// File: tb/tb_input0_arbiter_wrapper.sv
// Self-checking bench for input0_arbiter_wrapper: directed vector table, random
// transactions against an arithmetic XY-route model, reset/timeout sequences.
module tb_input0_arbiter_wrapper;

    localparam int PKT_LEN = 8;
    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       router_start_req;
    logic [9:0] router_scr_addr;
    logic [9:0] router_dst_addr;
    logic [4:0] out_gnt;
    logic [4:0] out_req;
    logic       conn_valid;
    logic [2:0] conn_port;
    logic       busy;
    logic       route_done;
    logic       route_err;

    int n_checks = 0;
    int n_errors = 0;
    int start_hold = 0;

    typedef struct {
        string      name;
        logic [9:0] src;
        logic [9:0] dst;
        logic [2:0] port;
        int         delay;
        int         hold;
        bit         noisy;
        int         gap;
    } vec_t;

    vec_t tbl[11];

    input0_arbiter_wrapper #(
        .ADDR_W   (10),
        .COL_BITS (2),
        .PKT_LEN  (PKT_LEN),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .router_start_req (router_start_req),
        .router_scr_addr  (router_scr_addr),
        .router_dst_addr  (router_dst_addr),
        .out_gnt          (out_gnt),
        .out_req          (out_req),
        .conn_valid       (conn_valid),
        .conn_port        (conn_port),
        .busy             (busy),
        .route_done       (route_done),
        .route_err        (route_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference XY route from mesh coordinates: x = addr mod 4, y = addr div 4
    function automatic logic [2:0] ref_port(input int src, input int dst);
        int sx, sy, dx, dy;
        sx = src % 4;
        sy = src / 4;
        dx = dst % 4;
        dy = dst / 4;
        if (dx > sx) return 3'd2;
        if (dx < sx) return 3'd4;
        if (dy > sy) return 3'd3;
        if (dy < sy) return 3'd1;
        return 3'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Advance to the next falling edge; release start once its hold count runs out
    task automatic step();
        @(negedge clk);
        if (start_hold > 0) begin
            start_hold--;
            if (start_hold == 0) router_start_req = 1'b0;
        end
    endtask

    task automatic idle_check(input string name, input int cycles);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (busy !== 1'b0 || out_req !== 5'b00000 || conn_valid !== 1'b0) ok = 1'b0;
        end
        check({name, "_idle"}, 32'(ok), 32'd1);
    endtask

    // One complete request; called at a falling edge with the DUT idle
    task automatic run_txn(input string name, input logic [9:0] src, input logic [9:0] dst,
                           input logic [2:0] exp_port, input int delay, input int hold,
                           input bit noisy, input bit pulse_mid);
        logic [4:0] exp_req;
        logic [4:0] noise;
        int         xfer_cnt;
        int         guard;
        bit         ok;
        exp_req = 5'b00001 << exp_port;
        noise   = noisy ? (5'($urandom) & ~exp_req) : 5'b00000;
        router_scr_addr  = src;
        router_dst_addr  = dst;
        router_start_req = 1'b1;
        start_hold       = hold;
        out_gnt          = noise;
        step();
        check({name, "_route"}, {26'd0, busy, out_req}, {26'd0, 1'b1, 5'b00000});
        step();
        ok = 1'b1;
        for (int k = 0; k <= delay; k++) begin
            if (out_req !== exp_req || conn_valid !== 1'b0 || busy !== 1'b1) ok = 1'b0;
            if (k == delay) out_gnt = exp_req | noise;
            step();
        end
        check({name, "_req"}, 32'(ok), 32'd1);
        check({name, "_xfer_start"}, {28'd0, conn_valid, conn_port}, {28'd0, 1'b1, exp_port});
        xfer_cnt = 0;
        guard    = 0;
        ok       = 1'b1;
        while (route_done !== 1'b1 && guard < 300) begin
            if (conn_valid === 1'b1) begin
                xfer_cnt++;
                if (out_req !== exp_req || conn_port !== exp_port) ok = 1'b0;
            end
            if (route_err !== 1'b0) ok = 1'b0;
            if (noisy && xfer_cnt == 2) out_gnt = 5'b00000;
            if (pulse_mid && xfer_cnt == 3) begin
                router_start_req = 1'b1;
                start_hold       = 1000;
            end
            step();
            guard++;
        end
        check({name, "_xfer_fields"}, 32'(ok), 32'd1);
        check({name, "_xfer_len"}, 32'(xfer_cnt), 32'(PKT_LEN));
        check({name, "_done"}, {25'd0, route_done, conn_valid, out_req},
              {25'd0, 1'b1, 1'b0, 5'b00000});
        out_gnt = 5'b00000;
        step();
        check({name, "_post"}, {29'd0, busy, route_done, conn_valid}, 32'd0);
    endtask

    initial begin
        tbl[0]  = '{"basic",        10'h001, 10'h005, 3'd3, 0,  2, 1'b0, 1};
        tbl[1]  = '{"b2b_a",        10'h002, 10'h006, 3'd3, 0,  1, 1'b0, 18};
        tbl[2]  = '{"b2b_b",        10'h000, 10'h004, 3'd3, 0,  1, 1'b0, 2};
        tbl[3]  = '{"east",         10'h001, 10'h003, 3'd2, 0,  1, 1'b0, 1};
        tbl[4]  = '{"west",         10'h003, 10'h001, 3'd4, 1,  1, 1'b0, 1};
        tbl[5]  = '{"north",        10'h005, 10'h001, 3'd1, 0,  1, 1'b1, 1};
        tbl[6]  = '{"local",        10'h005, 10'h005, 3'd0, 2,  1, 1'b0, 1};
        tbl[7]  = '{"delayed",      10'h001, 10'h003, 3'd2, 10, 1, 1'b1, 1};
        tbl[8]  = '{"corner_west",  10'h3FF, 10'h000, 3'd4, 0,  1, 1'b0, 1};
        tbl[9]  = '{"corner_north", 10'h3FC, 10'h000, 3'd1, 0,  1, 1'b0, 1};
        tbl[10] = '{"corner_east",  10'h000, 10'h3FF, 3'd2, 0,  1, 1'b0, 1};

        rst              = 1'b1;
        router_start_req = 1'b0;
        router_scr_addr  = 10'h000;
        router_dst_addr  = 10'h000;
        out_gnt          = 5'b00000;
        step();
        step();
        check("reset_outputs", {18'd0, out_req, conn_valid, conn_port, busy, route_done, route_err},
              32'd0);
        rst = 1'b0;
        idle_check("reset", 4);

        for (int i = 0; i < 11; i++) begin
            run_txn(tbl[i].name, tbl[i].src, tbl[i].dst, tbl[i].port,
                    tbl[i].delay, tbl[i].hold, tbl[i].noisy, 1'b0);
            idle_check(tbl[i].name, tbl[i].gap);
        end

        // Held level: only one request; then an edge during XFER is dropped
        run_txn("hold_level", 10'h001, 10'h005, 3'd3, 0, 1000, 1'b0, 1'b0);
        idle_check("hold_level", 3);
        start_hold = 0;
        router_start_req = 1'b0;
        step();
        run_txn("mid_edge", 10'h005, 10'h001, 3'd1, 0, 1, 1'b0, 1'b1);
        idle_check("mid_edge", 3);
        start_hold = 0;
        router_start_req = 1'b0;
        step();

        for (int r = 0; r < 24; r++) begin
            logic [9:0] s;
            logic [9:0] d;
            s = 10'($urandom_range(0, 1023));
            d = ($urandom_range(0, 3) == 0) ? s : 10'($urandom_range(0, 1023));
            run_txn("rand", s, d, ref_port(int'(s), int'(d)), $urandom_range(0, 6),
                    $urandom_range(1, 3), 1'b1, 1'b0);
            idle_check("rand", $urandom_range(1, 3));
        end

        // Reset during XFER discards the connection
        router_scr_addr  = 10'h001;
        router_dst_addr  = 10'h005;
        router_start_req = 1'b1;
        start_hold       = 1;
        out_gnt          = 5'b01000;
        step();
        step();
        step();
        check("rst_mid_pre", 32'(conn_valid), 32'd1);
        step();
        step();
        rst = 1'b1;
        step();
        check("rst_mid_outputs", {18'd0, out_req, conn_valid, conn_port, busy, route_done, route_err},
              32'd0);
        rst = 1'b0;
        idle_check("rst_mid", 4);
        out_gnt = 5'b00000;

`ifdef INPUT0_ARB_TIMEOUT_EN
        begin
            int req_cycles;
            int guard;
            bit ok;
            router_scr_addr  = 10'h001;
            router_dst_addr  = 10'h003;
            router_start_req = 1'b1;
            start_hold       = 1;
            out_gnt          = 5'b11011;
            step();
            step();
            req_cycles = 0;
            guard      = 0;
            ok         = 1'b1;
            while (out_req !== 5'b00000 && guard < 200) begin
                req_cycles++;
                if (conn_valid !== 1'b0 || route_done !== 1'b0 || route_err !== 1'b0) ok = 1'b0;
                step();
                guard++;
            end
            check("timeout_wait", 32'(ok), 32'd1);
            check("timeout_len", 32'(req_cycles), 32'(TIMEOUT));
            check("timeout_err", {29'd0, route_err, route_done, busy}, {29'd0, 1'b1, 1'b0, 1'b0});
            out_gnt = 5'b00000;
            step();
            check("timeout_pulse", 32'(route_err), 32'd0);
            idle_check("timeout", 2);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
